// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter
//   Arbitrates fixed-length SDRAM burst commands between the camera write
//   stream and the display read stream, and rotates the frame buffers
//   between the two streams.
//   Optional build macro: SDRAM_TRIPLE_BUF_EN selects three rotating buffers
//   instead of the default two, so the camera never overwrites a pending frame.
module sdram_frame_arbiter #(
   parameter int ADDR_W        = 24,
   parameter int LVL_W         = 10,
   parameter int FRAME_WORDS   = 307200,
   parameter int BURST_LEN     = 256,
   parameter int BUF_STRIDE    = 524288,
   parameter int RD_FIFO_DEPTH = 512,
   parameter int RD_URGENT     = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_frame_start,
   input  logic [LVL_W-1:0]  wr_fifo_level,
   input  logic              rd_frame_start,
   input  logic [LVL_W-1:0]  rd_fifo_level,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_write,
   output logic [ADDR_W-1:0] cmd_addr,
   input  logic              burst_done,
   output logic [1:0]        wr_buf,
   output logic [1:0]        rd_buf,
   output logic              frame_overrun
);

   localparam logic [ADDR_W-1:0] FRAME_A   = ADDR_W'(FRAME_WORDS);
   localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(BUF_STRIDE);
   localparam logic [31:0]       BURST_U   = 32'(BURST_LEN);
   localparam logic [31:0]       RD_ROOM_U = 32'(RD_FIFO_DEPTH - BURST_LEN);
   localparam logic [31:0]       URGENT_U  = 32'(RD_URGENT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state, state_d;
   logic              cmd_valid_d, cmd_write_d, frame_overrun_d;
   logic [ADDR_W-1:0] cmd_addr_d;
   logic [ADDR_W-1:0] wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
   logic              wr_active, wr_active_d, rd_active, rd_active_d;
   logic              last_grant_wr, last_grant_wr_d;
   logic [1:0]        ready_buf, ready_buf_d, wr_buf_d, rd_buf_d;
   logic              ready_valid, ready_valid_d;
   logic              promote;
   logic              wr_elig, rd_elig, rd_urgent, grant_wr, grant_rd;
   logic [31:0]       wr_lvl_u, rd_lvl_u;

   // Burst start address inside a buffer, truncated to the address width.
   function automatic logic [ADDR_W-1:0] burst_addr(input logic [1:0] b,
                                                    input logic [ADDR_W-1:0] p);
      return ADDR_W'(b) * STRIDE_A + p;
   endfunction

`ifdef SDRAM_TRIPLE_BUF_EN
   // Free buffer for the camera: neither scanned nor pending. When the reader
   // has just taken the pending frame, step to the buffer after it.
   function automatic logic [1:0] pick_wr_buf(input logic [1:0] rd_b,
                                              input logic [1:0] rdy_b);
      if (rd_b != rdy_b) return 2'd3 - rd_b - rdy_b;
      return (rd_b == 2'd2) ? 2'd0 : rd_b + 2'd1;
   endfunction
`endif

   assign wr_lvl_u  = 32'(wr_fifo_level);
   assign rd_lvl_u  = 32'(rd_fifo_level);
   assign wr_elig   = wr_active && (wr_ptr < FRAME_A) && (wr_lvl_u >= BURST_U);
   assign rd_elig   = rd_active && (rd_ptr < FRAME_A) && (rd_lvl_u <= RD_ROOM_U);
   assign rd_urgent = rd_elig && (rd_lvl_u < URGENT_U);
   // Urgent reads win outright; otherwise alternate, falling back to whoever is eligible.
   assign grant_rd  = rd_urgent || (rd_elig && (!wr_elig || last_grant_wr));
   assign grant_wr  = wr_elig && !grant_rd;

   // Next-state, command and frame-rotation logic.
   always_comb begin
      state_d         = state;
      cmd_valid_d     = cmd_valid;
      cmd_write_d     = cmd_write;
      cmd_addr_d      = cmd_addr;
      last_grant_wr_d = last_grant_wr;
      wr_ptr_d        = wr_ptr;
      rd_ptr_d        = rd_ptr;
      wr_active_d     = wr_active;
      rd_active_d     = rd_active;
      ready_buf_d     = ready_buf;
      ready_valid_d   = ready_valid;
      rd_buf_d        = rd_buf;
      wr_buf_d        = wr_buf;
      frame_overrun_d = 1'b0;
      promote         = 1'b0;

      case (state)
         IDLE: begin
            if (grant_rd || grant_wr) begin
               cmd_valid_d     = 1'b1;
               cmd_write_d     = grant_wr;
               cmd_addr_d      = grant_wr ? burst_addr(wr_buf, wr_ptr)
                                          : burst_addr(rd_buf, rd_ptr);
               last_grant_wr_d = grant_wr;
               state_d         = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               if (cmd_write) wr_ptr_d = wr_ptr + BURST_A;
               else           rd_ptr_d = rd_ptr + BURST_A;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (burst_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Frame boundaries override any pointer advance in the same cycle.
      if (wr_frame_start) begin
         if (wr_ptr == FRAME_A) begin
            ready_buf_d   = wr_buf;
            ready_valid_d = 1'b1;
            promote       = 1'b1;
         end else if (wr_active) begin
            frame_overrun_d = 1'b1;
         end
         wr_active_d = 1'b1;
         wr_ptr_d    = '0;
      end

      // Reader sees a promotion made in this same cycle.
      if (rd_frame_start) begin
         if (ready_valid_d) begin
            rd_buf_d      = ready_buf_d;
            ready_valid_d = 1'b0;
         end
         rd_active_d = 1'b1;
         rd_ptr_d    = '0;
      end

`ifdef SDRAM_TRIPLE_BUF_EN
      if (promote) wr_buf_d = pick_wr_buf(rd_buf_d, ready_buf_d);
`else
      // Two buffers: the camera always owns the buffer the display is not scanning.
      if (promote || rd_frame_start) wr_buf_d = {1'b0, ~rd_buf_d[0]};
`endif
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cmd_valid     <= 1'b0;
         cmd_write     <= 1'b0;
         cmd_addr      <= '0;
         frame_overrun <= 1'b0;
         last_grant_wr <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         wr_active     <= 1'b0;
         rd_active     <= 1'b0;
         ready_buf     <= 2'd0;
         ready_valid   <= 1'b0;
         rd_buf        <= 2'd0;
         wr_buf        <= 2'd1;
      end else begin
         state         <= state_d;
         cmd_valid     <= cmd_valid_d;
         cmd_write     <= cmd_write_d;
         cmd_addr      <= cmd_addr_d;
         frame_overrun <= frame_overrun_d;
         last_grant_wr <= last_grant_wr_d;
         wr_ptr        <= wr_ptr_d;
         rd_ptr        <= rd_ptr_d;
         wr_active     <= wr_active_d;
         rd_active     <= rd_active_d;
         ready_buf     <= ready_buf_d;
         ready_valid   <= ready_valid_d;
         rd_buf        <= rd_buf_d;
         wr_buf        <= wr_buf_d;
      end
   end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// tb_sdram_frame_arbiter
//   Scoreboard bench: each phase applies frame starts and static FIFO levels,
//   a transaction-level model predicts the burst command sequence into a
//   queue, and a monitor compares every accepted command against it.
module tb_sdram_frame_arbiter;
   localparam int ADDR_W = 24;
   localparam int LVL_W  = 10;
   localparam int FW     = 64;
   localparam int BL     = 16;
   localparam int STRIDE = 256;
   localparam int DEPTH  = 128;
   localparam int URG    = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, wr_frame_start, rd_frame_start, cmd_ready, burst_done;
   logic [LVL_W-1:0]  wr_fifo_level, rd_fifo_level;
   logic              cmd_valid, cmd_write, frame_overrun;
   logic [ADDR_W-1:0] cmd_addr;
   logic [1:0]        wr_buf, rd_buf;

   sdram_frame_arbiter #(
      .ADDR_W(ADDR_W), .LVL_W(LVL_W), .FRAME_WORDS(FW), .BURST_LEN(BL),
      .BUF_STRIDE(STRIDE), .RD_FIFO_DEPTH(DEPTH), .RD_URGENT(URG)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_frame_start(wr_frame_start), .wr_fifo_level(wr_fifo_level),
      .rd_frame_start(rd_frame_start), .rd_fifo_level(rd_fifo_level),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .burst_done(burst_done),
      .wr_buf(wr_buf), .rd_buf(rd_buf), .frame_overrun(frame_overrun)
   );

   typedef struct packed {
      logic              w;
      logic [ADDR_W-1:0] a;
   } cmd_t;

   cmd_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   acc_cnt = 0;
   int   force_stall = -1;

   // Reference model state
   int m_wr_ptr, m_rd_ptr, m_wr_buf, m_rd_buf, m_rdy_buf;
   bit m_wr_act, m_rd_act, m_last_wr, m_rv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_wr_ptr = 0; m_rd_ptr = 0; m_wr_act = 0; m_rd_act = 0; m_last_wr = 0;
      m_rd_buf = 0; m_wr_buf = 1; m_rdy_buf = 0; m_rv = 0;
      exp_q.delete();
   endtask

   task automatic model_frame(input bit ws, input bit rs, output bit ovr);
      bit promo;
      promo = 0; ovr = 0;
      if (ws) begin
         if (m_wr_ptr == FW) begin
            m_rdy_buf = m_wr_buf; m_rv = 1; promo = 1;
         end else if (m_wr_act) begin
            ovr = 1;
         end
         m_wr_act = 1; m_wr_ptr = 0;
      end
      if (rs) begin
         if (m_rv) begin m_rd_buf = m_rdy_buf; m_rv = 0; end
         m_rd_act = 1; m_rd_ptr = 0;
      end
`ifdef SDRAM_TRIPLE_BUF_EN
      if (promo) begin
         for (int k = 2; k >= 1; k--) begin
            int c;
            c = (m_rd_buf + k) % 3;
            if (c != m_rd_buf && c != m_rdy_buf) m_wr_buf = c;
         end
      end
`else
      if (promo || rs) m_wr_buf = 1 - m_rd_buf;
`endif
   endtask

   // Predict the commands issued while the levels stay constant.
   task automatic gen_cmds(input int wl, input int rl, input int limit, output int n);
      bit we, re, pick_w;
      cmd_t c;
      n = 0;
      while (limit == 0 || n < limit) begin
         we = m_wr_act && m_wr_ptr < FW && wl >= BL;
         re = m_rd_act && m_rd_ptr < FW && rl <= DEPTH - BL;
         if (!we && !re) break;
         pick_w = !(re && (rl < URG || !we || m_last_wr));
         c.w = pick_w;
         if (pick_w) begin
            c.a = ADDR_W'(m_wr_buf * STRIDE + m_wr_ptr); m_wr_ptr += BL;
         end else begin
            c.a = ADDR_W'(m_rd_buf * STRIDE + m_rd_ptr); m_rd_ptr += BL;
         end
         m_last_wr = pick_w;
         exp_q.push_back(c);
         n++;
      end
   endtask

   task automatic park();
      wr_fifo_level = '0;
      rd_fifo_level = LVL_W'(DEPTH);
   endtask

   task automatic run_phase(input bit ws, input bit rs, input int wl, input int rl,
                            input int limit, input string tag);
      bit ovr;
      int n, base, guard;
      @(negedge clk);
      wr_frame_start = ws; rd_frame_start = rs;
      model_frame(ws, rs, ovr);
      @(negedge clk);
      wr_frame_start = 0; rd_frame_start = 0;
      #1;
      check($sformatf("%s_overrun", tag), frame_overrun, ovr);
      check($sformatf("%s_wr_buf", tag), wr_buf, m_wr_buf);
      check($sformatf("%s_rd_buf", tag), rd_buf, m_rd_buf);
      @(negedge clk);
      #1 check($sformatf("%s_overrun_end", tag), frame_overrun, 0);
      @(negedge clk);
      base = acc_cnt;
      gen_cmds(wl, rl, limit, n);
      wr_fifo_level = LVL_W'(wl);
      rd_fifo_level = LVL_W'(rl);
      if (limit > 0) begin
         guard = 0;
         while (acc_cnt < base + n && guard < 3000) begin
            @(negedge clk); #2; guard++;
         end
         @(negedge clk);
         park();
      end
      guard = 0;
      while (exp_q.size() != 0 && guard < 3000) begin
         @(negedge clk); guard++;
      end
      check($sformatf("%s_drained", tag), exp_q.size(), 0);
      exp_q.delete();
      repeat (12) @(negedge clk);
      park();
   endtask

   // Monitor: compares accepted commands and checks stall stability.
   initial begin
      bit pv, pr, pw;
      logic [ADDR_W-1:0] pa;
      cmd_t e;
      pv = 0; pr = 0; pw = 0; pa = '0;
      forever begin
         @(negedge clk); #1;
         if (rst_n) begin
            if (pv && !pr) begin
               check("hold_valid", cmd_valid, 1);
               check("hold_write", cmd_write, pw);
               check("hold_addr", cmd_addr, pa);
            end
            if (cmd_valid && cmd_ready) begin
               acc_cnt++;
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_cmd: got write=%0d addr=%0d, required no command",
                           cmd_write, cmd_addr);
               end else begin
                  e = exp_q.pop_front();
                  check("cmd_write", cmd_write, e.w);
                  check("cmd_addr", cmd_addr, e.a);
               end
            end
`ifndef SDRAM_TRIPLE_BUF_EN
            check("wr_buf_range", wr_buf <= 2'd1, 1);
`endif
         end
         pv = cmd_valid; pr = cmd_ready; pw = cmd_write; pa = cmd_addr;
      end
   end

   // SDRAM controller responder: random accept stall and completion delay.
   initial begin
      int n;
      cmd_ready = 0; burst_done = 0;
      forever begin
         @(negedge clk);
         burst_done = 0;
         if (cmd_valid && rst_n) begin
            n = (force_stall >= 0) ? force_stall : $urandom_range(0, 6);
            repeat (n) @(negedge clk);
            cmd_ready = 1;
            @(negedge clk);
            cmd_ready = 0;
            n = $urandom_range(0, 3);
            repeat (n) @(negedge clk);
            burst_done = 1;
         end
      end
   end

   // Stimulus
   initial begin
      bit ovr;
      int n, base, guard;
      rst_n = 0; wr_frame_start = 0; rd_frame_start = 0;
      wr_fifo_level = LVL_W'(16); rd_fifo_level = '0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_cmd_write", cmd_write, 0);
      check("rst_cmd_addr", cmd_addr, 0);
      check("rst_overrun", frame_overrun, 0);
      check("rst_rd_buf", rd_buf, 0);
      check("rst_wr_buf", wr_buf, 1);
      @(negedge clk);
      park();
      rst_n = 1;
      repeat (3) @(negedge clk);

      force_stall = 5;
      run_phase(1, 0, 16, DEPTH, 0, "wr_only");
      force_stall = -1;
      run_phase(1, 1, 16, 64, 0, "alternate");
      run_phase(1, 1, 20, 10, 0, "urgent");
      run_phase(1, 1, 16, DEPTH, 2, "partial");
      run_phase(1, 1, 0, DEPTH, 0, "overrun");

      for (int i = 0; i < 25; i++) begin
         bit ws, rs;
         int wl, rl, lim;
         ws  = ($urandom_range(0, 3) != 0);
         rs  = ($urandom_range(0, 3) != 0);
         wl  = $urandom_range(0, 40);
         rl  = $urandom_range(0, DEPTH);
         lim = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         run_phase(ws, rs, wl, rl, lim, $sformatf("rand%0d", i));
      end

      // Reset while a burst is in flight.
      @(negedge clk);
      wr_frame_start = 1;
      model_frame(1, 0, ovr);
      @(negedge clk);
      wr_frame_start = 0;
      base = acc_cnt;
      gen_cmds(16, DEPTH, 1, n);
      wr_fifo_level = LVL_W'(16);
      guard = 0;
      while (acc_cnt < base + n && guard < 3000) begin
         @(negedge clk); #2; guard++;
      end
      check("wait_accept", acc_cnt, base + n);
      @(negedge clk);
      rst_n = 0;
      model_reset();
      @(negedge clk);
      #1;
      check("wait_rst_cmd_valid", cmd_valid, 0);
      check("wait_rst_cmd_write", cmd_write, 0);
      check("wait_rst_cmd_addr", cmd_addr, 0);
      check("wait_rst_overrun", frame_overrun, 0);
      check("wait_rst_rd_buf", rd_buf, 0);
      check("wait_rst_wr_buf", wr_buf, 1);
      @(negedge clk);
      rst_n = 1;
      repeat (15) @(negedge clk);
      #1 check("post_rst_idle", cmd_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
